// File: rtl/reg_file.sv
// reg_file: RV32I integer register file, two combinational read ports and one synchronous write port.
// x0 is never written and always reads zero; reads return the pre-edge value during a write.
module reg_file #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            we3,
    input  logic [AW-1:0]   a1,
    input  logic [AW-1:0]   a2,
    input  logic [AW-1:0]   a3,
    input  logic [XLEN-1:0] wd3,
    output logic [XLEN-1:0] rd1,
    output logic [XLEN-1:0] rd2
);
    logic [XLEN-1:0] regs [NREGS];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else if (we3 && a3 != '0) begin
            regs[a3] <= wd3;
        end
    end

    assign rd1 = (a1 == '0) ? '0 : regs[a1];
    assign rd2 = (a2 == '0) ? '0 : regs[a2];
endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: scoreboard bench for reg_file, checking reads against a behavioural register model.
module tb_reg_file;
    logic        clk = 0;
    logic        rst = 0;
    logic        we3 = 0;
    logic [4:0]  a1 = 0, a2 = 0, a3 = 0;
    logic [31:0] wd3 = 0;
    logic [31:0] rd1, rd2;
    logic [31:0] model [32];
    logic [31:0] exp_q [$];
    int          checks = 0;
    int          failures = 0;

    reg_file dut (.clk(clk), .rst(rst), .we3(we3), .a1(a1), .a2(a2), .a3(a3), .wd3(wd3), .rd1(rd1), .rd2(rd2));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mval(input logic [4:0] a);
        return (a == 0) ? 32'h0 : model[a];
    endfunction

    // Model commits exactly what the DUT sees at the edge, then inputs move 1ns later.
    task automatic tick();
        @(posedge clk);
        if (rst) for (int i = 0; i < 32; i++) model[i] = 32'h0;
        else if (we3 && a3 != 0) model[a3] = wd3;
        #1;
    endtask

    task automatic rd(input logic [4:0] x, input logic [4:0] y, input string tag);
        a1 = x;
        a2 = y;
        exp_q.push_back(mval(x));
        exp_q.push_back(mval(y));
        #1;
        check({tag, "_rd1"}, rd1, exp_q.pop_front());
        check({tag, "_rd2"}, rd2, exp_q.pop_front());
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d, input int n);
        we3 = 1;
        a3 = a;
        wd3 = d;
        repeat (n) tick();
        we3 = 0;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) model[i] = 32'hx;
        @(negedge clk);
        rst = 1;
        tick();
        rst = 0;
        rd(5, 31, "reset");
        rd(0, 17, "reset_x0");
        wr(1, 32'h12345678, 2);
        tick();
        tick();
        rd(1, 0, "wr1");
        check("wr1_const", rd1, 32'h12345678);
        wr(2, 32'h87654321, 2);
        tick();
        tick();
        rd(1, 2, "wr2");
        check("wr2_const", rd2, 32'h87654321);
        wr(0, 32'hDEADBEEF, 1);
        rd(0, 0, "x0");
        check("x0_const", rd1, 32'h0);
        we3 = 0;
        a3 = 1;
        wd3 = 32'hFFFFFFFF;
        tick();
        tick();
        rd(1, 1, "we_off");
        check("we_off_const", rd1, 32'h12345678);
        wr(3, 32'h33333333, 1);
        we3 = 1;
        a3 = 3;
        wd3 = 32'hA5A5A5A5;
        rd(3, 3, "rdw_old");
        check("rdw_old_const", rd1, 32'h33333333);
        tick();
        we3 = 0;
        rd(3, 3, "rdw_new");
        check("rdw_new_const", rd1, 32'hA5A5A5A5);
        wr(31, 32'h11111111, 1);
        wr(31, 32'h22222222, 1);
        rd(31, 30, "b2b");
        check("b2b_const", rd1, 32'h22222222);
        for (int k = 0; k < 40; k++) begin
            we3 = 1'($urandom_range(0, 1));
            a3 = 5'($urandom);
            wd3 = $urandom;
            rd(5'($urandom), a3, "rand_pre");
            tick();
            we3 = 0;
            rd(a3, 5'($urandom), "rand_post");
        end
        rst = 1;
        we3 = 1;
        a3 = 4;
        wd3 = 32'h1;
        tick();
        rst = 0;
        we3 = 0;
        rd(4, 1, "rst_pri");
        check("rst_pri_const", rd1, 32'h0);
        rd(2, 3, "rst_pri_regs");
        rd(31, 16, "rst_pri_hi");
        check("sb_empty", 32'(exp_q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
